// File: rtl/ir_tx_nec.sv
// ir_tx_nec: NEC-format infrared transmitter.
//
// Accepts one 32-bit frame, or one repeat request, on a valid/ready
// handshake. Drives a carrier-modulated IR line: idle high, carrier marks are
// low pulses. bits [7:0] of tx_data go out first, LSB first.
//
// Ports:
//   clk         in   clock (25 MHz nominal)
//   rst_n       in   asynchronous active-low reset
//   tx_data     in   32-bit frame payload, sampled at accept
//   tx_repeat   in   1 = send a repeat code (tx_data ignored), sampled at accept
//   tx_valid    in   request
//   tx_ready    out  high only in IDLE
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse after the stop mark ends
//   ir_sd_o     out  registered modulated IR line, idle 1
//   o_dbg_state out  current FSM state (debug)
//
// Handshake: a request is accepted on a rising edge where tx_valid and
// tx_ready are both high. tx_valid seen while tx_ready is low is ignored, with
// no queuing, so the requester holds tx_valid until it is accepted.
module ir_tx_nec #(
  parameter int unsigned UNIT_CYC    = 14063,
  parameter int unsigned CARRIER_DIV = 658,
  parameter int unsigned CARRIER_LO  = 219,
  parameter int unsigned FRAME_UNITS = 192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tx_data,
  input  logic        tx_repeat,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        ir_sd_o,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);

  localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_LO     = CW'(CARRIER_LO);
  localparam logic [FW-1:0] FRAME_END  = FW'(FRAME_UNITS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_UNITS - 1);

  state_t        r_state;
  logic [UW-1:0] r_unit_cnt;
  logic [CW-1:0] r_car_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [4:0]    r_ph_cnt;
  logic [4:0]    r_bit_idx;
  logic [31:0]   r_shreg;
  logic          r_repeat;
  logic          r_done;
  logic          r_ir;

  logic       w_unit_tick;
  logic [4:0] w_ph_last;
  logic       w_ph_end;
  logic       w_mark;
  logic       w_frame_over;

  assign w_unit_tick = (r_state != S_IDLE) && (r_unit_cnt == UNIT_LAST);
  assign w_mark      = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                       (r_state == S_STOP_MARK);

  // Phase length in units, minus one, for the current state.
  always_comb begin
    w_ph_last = 5'd0;
    case (r_state)
      S_LEAD_MARK:  w_ph_last = 5'd15;
      S_LEAD_SPACE: w_ph_last = r_repeat ? 5'd3 : 5'd7;
      S_BIT_SPACE:  w_ph_last = r_shreg[0] ? 5'd2 : 5'd0;
      default:      w_ph_last = 5'd0;
    endcase
  end

  assign w_ph_end = w_unit_tick && (r_ph_cnt == w_ph_last);

  // GAP ends on the tick that brings the frame counter to FRAME_UNITS; the
  // saturated compare covers a frame longer than FRAME_UNITS.
  assign w_frame_over = (r_frame_cnt >= FRAME_END) ||
                        (w_unit_tick && (r_frame_cnt == FRAME_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_unit_cnt  <= '0;
      r_car_cnt   <= '0;
      r_frame_cnt <= '0;
      r_ph_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_repeat    <= 1'b0;
      r_done      <= 1'b0;
      r_ir        <= 1'b1;
    end else begin
      r_done <= 1'b0;
      // Output register: one clock behind the state/carrier it reflects.
      r_ir   <= ~(w_mark && (r_car_cnt < CAR_LO));

      if (r_state != S_IDLE) begin
        r_unit_cnt <= w_unit_tick ? '0 : r_unit_cnt + 1'b1;
        r_car_cnt  <= (r_car_cnt == CAR_LAST) ? '0 : r_car_cnt + 1'b1;
        if (w_unit_tick) begin
          r_ph_cnt <= w_ph_end ? '0 : r_ph_cnt + 1'b1;
          if (r_frame_cnt < FRAME_END)
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shreg     <= tx_data;
            r_repeat    <= tx_repeat;
            r_bit_idx   <= '0;
            r_unit_cnt  <= '0;
            r_frame_cnt <= '0;
            r_ph_cnt    <= '0;
            r_car_cnt   <= '0;
            r_state     <= S_LEAD_MARK;
          end
        end
        S_LEAD_MARK: begin
          if (w_ph_end) r_state <= S_LEAD_SPACE;
        end
        S_LEAD_SPACE: begin
          if (w_ph_end) begin
            r_car_cnt <= '0;
            r_state   <= r_repeat ? S_STOP_MARK : S_BIT_MARK;
          end
        end
        S_BIT_MARK: begin
          if (w_ph_end) r_state <= S_BIT_SPACE;
        end
        S_BIT_SPACE: begin
          if (w_ph_end) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
            r_car_cnt <= '0;
            r_state   <= (r_bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
        end
        S_STOP_MARK: begin
          if (w_ph_end) begin
            r_done  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_frame_over) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign ir_sd_o     = r_ir;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ir_tx_nec.sv
`timescale 1ns/1ps
module tb_ir_tx_nec;

  localparam int UNIT = 20;
  localparam int CDIV = 6;
  localparam int CLO  = 2;
  localparam int FRAME_CLK = 192 * UNIT;   // 3840

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_repeat = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, busy, done, ir_sd_o;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ir_tx_nec #(
    .UNIT_CYC(UNIT), .CARRIER_DIV(CDIV), .CARRIER_LO(CLO), .FRAME_UNITS(192)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_repeat(tx_repeat),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .ir_sd_o(ir_sd_o), .o_dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Envelope event: {is_mark, width in clocks, number of low samples}
  logic [28:0] exp_q[$];
  int          done_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int lows_of(input int w);
    return (w / CDIV) * CLO + (((w % CDIV) < CLO) ? (w % CDIV) : CLO);
  endfunction

  function automatic logic [28:0] ev(input logic k, input int w, input int l);
    return {k, w[15:0], l[11:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Pushes the expected envelope of one frame; returns its length to the
  // end of the stop mark, in units.
  function automatic int push_frame(input logic [31:0] d, input logic rep);
    int units;
    exp_q.push_back(ev(1'b1, 16 * UNIT, lows_of(16 * UNIT)));
    if (rep) begin
      exp_q.push_back(ev(1'b0, 4 * UNIT, 0));
      units = 20;
    end else begin
      exp_q.push_back(ev(1'b0, 8 * UNIT, 0));
      units = 24;
      for (int i = 0; i < 32; i++) begin
        exp_q.push_back(ev(1'b1, UNIT, lows_of(UNIT)));
        exp_q.push_back(ev(1'b0, d[i] ? 3 * UNIT : UNIT, 0));
        units += d[i] ? 4 : 2;
      end
    end
    exp_q.push_back(ev(1'b1, UNIT, lows_of(UNIT)));
    return units + 1;
  endfunction

  // ---------------- monitor ----------------
  // Demodulates ir_sd_o: a mark ends after 5 consecutive highs (the carrier
  // high phase is 4 clocks). Spaces of 200+ clocks are inter-frame gaps.
  bit in_mark = 0;
  bit have_space = 0;
  int hi_run = 0;
  int mark_start = 0;
  int last_lo = 0;
  int lows = 0;

  task automatic got(input logic [28:0] obs);
    logic [28:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL envelope_unexpected: got mark=%0b width=%0d lows=%0d, no event expected (cyc %0d)",
               obs[28], obs[27:12], obs[11:0], cyc);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_fail++;
        $display("FAIL envelope: got mark=%0b width=%0d lows=%0d expected mark=%0b width=%0d lows=%0d (cyc %0d)",
                 obs[28], obs[27:12], obs[11:0], e[28], e[27:12], e[11:0], cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_mark = 0; have_space = 0; hi_run = 0; lows = 0;
    end else begin
      if (ir_sd_o == 1'b0) begin
        if (!in_mark) begin
          if (have_space && hi_run < 200) got(ev(1'b0, hi_run, 0));
          have_space = 0;
          in_mark = 1;
          mark_start = cyc;
          lows = 0;
        end
        lows++;
        last_lo = cyc;
        hi_run = 0;
      end else begin
        hi_run++;
        if (in_mark && hi_run == 5) begin
          got(ev(1'b1, last_lo - mark_start + 1, lows));
          in_mark = 0;
          have_space = 1;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Returns acc = cycle count seen just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic rep, input bit hold, output int acc);
    int units;
    int guard;
    @(negedge clk);
    tx_data = d; tx_repeat = rep; tx_valid = 1'b1;
    guard = 0;
    while (!tx_ready && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", tx_ready, 1);
    units = push_frame(d, rep);
    @(negedge clk);
    acc = cyc;
    // done is visible in the cycle following the stop-mark end edge.
    done_q.push_back(acc + units * UNIT);
    if (!hold) tx_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_ready", tx_ready, 0);
    chk("ir_lag_high", ir_sd_o, 1);
    @(negedge clk);
    chk("ir_first_low", ir_sd_o, 0);
  endtask

  task automatic wait_idle(input int acc, input string name);
    int guard = 0;
    while (!tx_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk(name, cyc - acc, FRAME_CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir", ir_sd_o, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ir", ir_sd_o, 1);
    chk("rel_ready", tx_ready, 1);
    chk("rel_state", dbg_state, 0);

    // Data frame, with a tx_valid pulse and tx_data change mid-frame.
    send(32'h00FF_20DF, 1'b0, 1'b0, acc);
    repeat (1000) @(negedge clk);
    tx_valid = 1'b1; tx_data = 32'h1234_5678; tx_repeat = 1'b1;
    @(negedge clk);
    chk("busy_pulse_ready", tx_ready, 0);
    chk("busy_pulse_busy", busy, 1);
    tx_valid = 1'b0; tx_data = 32'hA5A5_5A5A; tx_repeat = 1'b0;
    wait_idle(acc, "data_idle");

    // Repeat frame.
    send(32'hFFFF_FFFF, 1'b1, 1'b0, acc);
    wait_idle(acc, "repeat_idle");

    // Extremes back to back with tx_valid held high.
    send(32'h0000_0000, 1'b0, 1'b1, acc);
    send(32'hFFFF_FFFF, 1'b0, 1'b0, acc2);
    chk("start_spacing", acc2 - acc, FRAME_CLK + 1);
    wait_idle(acc2, "ones_idle");

    // Async reset during BIT_SPACE of bit 10 (all-zero data: unit 45).
    send(32'h0000_0000, 1'b0, 1'b0, acc);
    while (cyc < acc + 45 * UNIT + 10) @(negedge clk);
    chk("pre_reset_state", dbg_state, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ir", ir_sd_o, 1);
    chk("async_busy", busy, 0);
    chk("async_ready", tx_ready, 1);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_reset_busy", busy, 0);

    send(32'h00FF_20DF, 1'b0, 1'b0, acc);
    wait_idle(acc, "post_reset_idle");

    repeat (50) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
